frame_scheduler: RTL
====================

# frame_scheduler

Sequences the three histogram-equalization stages (input histogram, CDF, output remap) across two ping-pong scratchpad banks so that histogramming of frame N+1 overlaps CDF/remap of frame N. Sits between the top level and the input, CDF and output pipelines. It issues their start pulses and bank offsets, captures each bank's CDF minimum, and computes the remap divisor.

## Interface
Parameters:
- NUM_PIXELS, default 76800: pixels per frame; must satisfy 1 ≤ NUM_PIXELS < 2^CNT_W.
- CNT_W, default 20: width of CDF/count values.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle frame request.
- start_drop  out  1  one-cycle pulse: start arrived while a request was already pending.
- input_start  out  1  one-cycle launch pulse to the input pipeline.
- input_base_offset  out  1  bank for the input pipeline; stable from launch until input_done.
- input_done  in  1  one-cycle completion pulse.
- cdf_start  out  1  one-cycle launch pulse to the CDF pipeline.
- cdf_base_offset  out  1  bank for the CDF pipeline.
- cdf_valid  in  1  cdf_min is valid this cycle.
- cdf_min  in  CNT_W  first non-zero CDF value of the current CDF bank.
- cdf_done  in  1  one-cycle completion pulse.
- output_start  out  1  one-cycle launch pulse to the output pipeline.
- output_base_offset  out  1  bank for the output pipeline.
- cdf_min_out  out  CNT_W  captured minimum for the output bank.
- divisor  out  CNT_W  NUM_PIXELS − cdf_min_out, forced to 1 if zero.
- output_done  in  1  one-cycle completion pulse.
- frame_done  out  1  one-cycle pulse per completed frame.
- busy  out  1  any bank not FREE, or a request pending.
- protocol_err  out  1  sticky error flag; cleared only by reset.

## Operation
Each bank has a state: FREE → HIST → HIST_RDY → CDF → CDF_RDY → OUT → FREE.

Three stage pointers (in_ptr, cdf_ptr, out_ptr) are each 1 bit and toggle on their stage's done. Each stage runs at most one job at a time.

Pending request:
- start sets `pending`.
- start while `pending` is already set: request dropped, start_drop pulses.

Launch rules. All three are evaluated every cycle from registered state, independently:
- **Input:** pending && input stage idle && bank[in_ptr]==FREE → input_start, input_base_offset=in_ptr, bank→HIST, clear pending.
- **CDF:** CDF stage idle && bank[cdf_ptr]==HIST_RDY → cdf_start, cdf_base_offset=cdf_ptr, bank→CDF, clear min_seen.
- **Output:** output stage idle && bank[out_ptr]==CDF_RDY → output_start, output_base_offset=out_ptr, bank→OUT. cdf_min_out and divisor are loaded in the same cycle from min_reg[out_ptr].

Done and capture events:
- input_done → bank[in_ptr]→HIST_RDY; in_ptr toggles.
- cdf_valid → min_reg[cdf_ptr]=cdf_min. Only the first cdf_valid per job is captured; later ones are ignored.
- cdf_done → bank→CDF_RDY; cdf_ptr toggles. cdf_valid coincident with cdf_done is still captured. If no cdf_valid was seen during the job: min_reg=0 and protocol_err is set.
- output_done → bank→FREE; out_ptr toggles; frame_done pulses next cycle.

Arithmetic: divisor = NUM_PIXELS − min_reg, computed at CNT_W bits. A result of 0 (uniform image) or any underflow (min_reg > NUM_PIXELS) is replaced by 1. Underflow also sets protocol_err.

Error cases:
- Any done/valid pulse while its stage is idle is ignored and sets protocol_err.
- Simultaneous events on different stages are all applied in the same edge.

## Timing
- Reset values: all outputs 0. Banks FREE, pointers 0, pending=0, min_reg=0.
- Reset mid-frame returns everything to reset state within one edge. Pipelines share the reset; no abort handshake.
- **Uniform latency of 2 cycles.** An event sampled at edge t updates state at t+1; the resulting launch pulse is high in cycle t+2:
  - start → input_start
  - input_done → cdf_start
  - cdf_done → output_start, with divisor and cdf_min_out valid in the same cycle and held until the next output launch.
- output_done at t → frame_done at t+1. A freed bank allows input_start at t+2 if a request is pending.
- Base offsets change only on their stage's launch.
- Steady state: at most two frames in flight, one per bank.

## Structure
- Package `eq_sched_pkg` holds:
  - `bank_state_t` enum;
  - CNT_W default;
  - divisor-saturation helper function.
- Sub-module `bank_state_tracker`: one instance per bank. It holds the state register and min_reg, with one-hot advance inputs from the three stages. The top-level module holds the pointers, pending flag, launch logic and divisor register.

## Test plan
- **Single frame, NUM_PIXELS=16.** start at cycle 0 → input_start in cycle 2 (bank 0). input_done at 10 → cdf_start at 12. cdf_valid with min=3 at 14, cdf_done at 20 → output_start at 22 with divisor=13. output_done at 30 → frame_done at 31; busy falls.
- **Back-to-back frames.** start at cycles 0 and 12 → second input_start goes to bank 1 while frame 0 is in CDF/output. A third start with both banks busy stays pending; input_start fires 2 cycles after bank 0's output_done.
- **Uniform image.** cdf_min=16 with NUM_PIXELS=16 → divisor=1, protocol_err stays 0. cdf_min=20 → divisor=1, protocol_err=1.
- **Missing cdf_valid.** cdf_done with no prior cdf_valid → cdf_min_out=0, divisor=16, protocol_err=1. Stray output_done while idle → protocol_err=1, state unchanged.
- **Double start.** start pulses on two consecutive cycles while pending → start_drop pulses once.
- **Reset mid-operation.** reset asserted during the CDF stage → next cycle all outputs 0 and banks FREE. A new start then launches on bank 0.

Source files
------------

// File: rtl/eq_sched_pkg.sv
// Shared types and helpers for the histogram-equalization frame scheduler.
package eq_sched_pkg;

   localparam int CNT_W_DEF = 20;

   typedef enum logic [2:0] {
      BANK_FREE     = 3'd0,
      BANK_HIST     = 3'd1,
      BANK_HIST_RDY = 3'd2,
      BANK_CDF      = 3'd3,
      BANK_CDF_RDY  = 3'd4,
      BANK_OUT      = 3'd5
   } bank_state_t;

   // A zero result (uniform frame) and an underflow both saturate to 1.
   function automatic logic [31:0] sat_divisor(input logic [31:0] num, input logic [31:0] min_v);
      logic [31:0] res;
      if (min_v >= num) res = 32'd1;
      else              res = num - min_v;
      return res;
   endfunction

endpackage

// File: rtl/bank_state_tracker.sv
// Lifecycle state and captured CDF minimum of one scratchpad bank.
// Advances one step per edge on the matching one-hot stage event; no backpressure.
module bank_state_tracker
   import eq_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_in_start,
   input  logic             i_in_done,
   input  logic             i_cdf_start,
   input  logic             i_cdf_done,
   input  logic             i_out_start,
   input  logic             i_out_done,
   input  logic             i_min_wr,
   input  logic [CNT_W-1:0] i_min_dat,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_min
);

   bank_state_t      r_state;
   bank_state_t      w_state_nxt;
   logic [CNT_W-1:0] r_min;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BANK_FREE:     if (i_in_start)  w_state_nxt = BANK_HIST;
         BANK_HIST:     if (i_in_done)   w_state_nxt = BANK_HIST_RDY;
         BANK_HIST_RDY: if (i_cdf_start) w_state_nxt = BANK_CDF;
         BANK_CDF:      if (i_cdf_done)  w_state_nxt = BANK_CDF_RDY;
         BANK_CDF_RDY:  if (i_out_start) w_state_nxt = BANK_OUT;
         BANK_OUT:      if (i_out_done)  w_state_nxt = BANK_FREE;
         default:                        w_state_nxt = BANK_FREE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= BANK_FREE;
         r_min   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (i_min_wr) r_min <= i_min_dat;
      end
   end

   assign o_state = r_state;
   assign o_min   = r_min;

endmodule

// File: rtl/frame_scheduler.sv
// Sequences hist/CDF/remap stages over two ping-pong banks and derives the remap divisor.
// Launches follow their trigger by 2 cycles; no backpressure, a start while one is pending is dropped.
module frame_scheduler
   import eq_sched_pkg::*;
#(
   parameter int NUM_PIXELS = 76800,
   parameter int CNT_W      = CNT_W_DEF
)(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   output logic             o_start_drop,
   output logic             o_input_start,
   output logic             o_input_base_offset,
   input  logic             i_input_done,
   output logic             o_cdf_start,
   output logic             o_cdf_base_offset,
   input  logic             i_cdf_valid,
   input  logic [CNT_W-1:0] i_cdf_min,
   input  logic             i_cdf_done,
   output logic             o_output_start,
   output logic             o_output_base_offset,
   output logic [CNT_W-1:0] o_cdf_min_out,
   output logic [CNT_W-1:0] o_divisor,
   input  logic             i_output_done,
   output logic             o_frame_done,
   output logic             o_busy,
   output logic             o_protocol_err
);

   localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIXELS);

   logic             r_pending, r_in_ptr, r_cdf_ptr, r_out_ptr, r_min_seen;
   logic             r_start_drop, r_input_start, r_input_off, r_cdf_start, r_cdf_off;
   logic             r_output_start, r_output_off, r_frame_done, r_protocol_err;
   logic [CNT_W-1:0] r_cdf_min_out, r_divisor;

   logic [2:0]       w_bank_state [2];
   logic [CNT_W-1:0] w_bank_min   [2];

   logic w_in_busy, w_cdf_busy, w_out_busy;
   logic w_in_launch, w_cdf_launch, w_out_launch;
   logic w_in_done_ok, w_cdf_done_ok, w_out_done_ok;
   logic w_min_cap, w_min_miss, w_underflow, w_err;
   logic [CNT_W-1:0] w_launch_min, w_launch_div;

   // A stage is busy exactly while the bank its pointer selects sits in that stage's active state.
   assign w_in_busy    = (w_bank_state[r_in_ptr]  == BANK_HIST);
   assign w_cdf_busy   = (w_bank_state[r_cdf_ptr] == BANK_CDF);
   assign w_out_busy   = (w_bank_state[r_out_ptr] == BANK_OUT);

   assign w_in_launch  = r_pending && !w_in_busy && (w_bank_state[r_in_ptr] == BANK_FREE);
   assign w_cdf_launch = !w_cdf_busy && (w_bank_state[r_cdf_ptr] == BANK_HIST_RDY);
   assign w_out_launch = !w_out_busy && (w_bank_state[r_out_ptr] == BANK_CDF_RDY);

   assign w_in_done_ok  = i_input_done  && w_in_busy;
   assign w_cdf_done_ok = i_cdf_done    && w_cdf_busy;
   assign w_out_done_ok = i_output_done && w_out_busy;

   assign w_min_cap    = i_cdf_valid && w_cdf_busy && !r_min_seen;
   assign w_min_miss   = w_cdf_done_ok && !r_min_seen && !i_cdf_valid;
   assign w_launch_min = w_bank_min[r_out_ptr];
   assign w_launch_div = CNT_W'(sat_divisor(32'(NUM_PIX_C), 32'(w_launch_min)));
   assign w_underflow  = w_out_launch && (w_launch_min > NUM_PIX_C);

   assign w_err = (i_input_done  && !w_in_busy)  ||
                  (i_cdf_valid   && !w_cdf_busy) ||
                  (i_cdf_done    && !w_cdf_busy) ||
                  (i_output_done && !w_out_busy) ||
                  w_min_miss || w_underflow;

   for (genvar g = 0; g < 2; g++) begin : g_bank
      localparam logic BANK_ID = 1'(g);
      bank_state_tracker #(.CNT_W(CNT_W)) u_bank (
         .i_clock     (i_clock),
         .i_reset     (i_reset),
         .i_in_start  (w_in_launch   && (r_in_ptr  == BANK_ID)),
         .i_in_done   (w_in_done_ok  && (r_in_ptr  == BANK_ID)),
         .i_cdf_start (w_cdf_launch  && (r_cdf_ptr == BANK_ID)),
         .i_cdf_done  (w_cdf_done_ok && (r_cdf_ptr == BANK_ID)),
         .i_out_start (w_out_launch  && (r_out_ptr == BANK_ID)),
         .i_out_done  (w_out_done_ok && (r_out_ptr == BANK_ID)),
         .i_min_wr    ((w_min_cap || w_min_miss) && (r_cdf_ptr == BANK_ID)),
         .i_min_dat   (w_min_cap ? i_cdf_min : '0),
         .o_state     (w_bank_state[g]),
         .o_min       (w_bank_min[g])
      );
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pending      <= 1'b0;
         r_in_ptr       <= 1'b0;
         r_cdf_ptr      <= 1'b0;
         r_out_ptr      <= 1'b0;
         r_min_seen     <= 1'b0;
         r_start_drop   <= 1'b0;
         r_input_start  <= 1'b0;
         r_input_off    <= 1'b0;
         r_cdf_start    <= 1'b0;
         r_cdf_off      <= 1'b0;
         r_output_start <= 1'b0;
         r_output_off   <= 1'b0;
         r_cdf_min_out  <= '0;
         r_divisor      <= '0;
         r_frame_done   <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         // A start colliding with an already-set pending is lost even if that request launches now.
         r_pending    <= w_in_launch ? 1'b0 : (r_pending | i_start);
         r_start_drop <= i_start && r_pending;

         r_input_start <= w_in_launch;
         if (w_in_launch)  r_input_off <= r_in_ptr;
         if (w_in_done_ok) r_in_ptr    <= ~r_in_ptr;

         r_cdf_start <= w_cdf_launch;
         if (w_cdf_launch)       r_min_seen <= 1'b0;
         else if (w_min_cap)     r_min_seen <= 1'b1;
         if (w_cdf_launch)  r_cdf_off <= r_cdf_ptr;
         if (w_cdf_done_ok) r_cdf_ptr <= ~r_cdf_ptr;

         r_output_start <= w_out_launch;
         if (w_out_launch) begin
            r_output_off  <= r_out_ptr;
            r_cdf_min_out <= w_launch_min;
            r_divisor     <= w_launch_div;
         end
         if (w_out_done_ok) r_out_ptr <= ~r_out_ptr;
         r_frame_done <= w_out_done_ok;

         if (w_err) r_protocol_err <= 1'b1;
      end
   end

   assign o_start_drop         = r_start_drop;
   assign o_input_start        = r_input_start;
   assign o_input_base_offset  = r_input_off;
   assign o_cdf_start          = r_cdf_start;
   assign o_cdf_base_offset    = r_cdf_off;
   assign o_output_start       = r_output_start;
   assign o_output_base_offset = r_output_off;
   assign o_cdf_min_out        = r_cdf_min_out;
   assign o_divisor            = r_divisor;
   assign o_frame_done         = r_frame_done;
   assign o_protocol_err       = r_protocol_err;
   assign o_busy = r_pending || (w_bank_state[0] != BANK_FREE) || (w_bank_state[1] != BANK_FREE);

endmodule
